ucsbece154_icache: RTL and testbench
====================================

UCSBECE154_ICACHE -- requirements
Module: ucsbece154_icache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8, number of sets; power of two, at least 2.
REQ-002 SHALL have parameter BLOCK_WORDS, default 4, 32-bit words per line; power of two; must match the memory burst length.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port ReadEnable  input  1  CPU fetch request; held high by CPU until Ready.
REQ-006 SHALL have port ReadAddress  input  32  CPU fetch byte address, word aligned; held stable until Ready.
REQ-007 SHALL have port Instruction  output  32  fetched word, valid when Ready=1.
REQ-008 SHALL have port Ready  output  1  one-cycle pulse per completed fetch.
REQ-009 SHALL have port MemReadRequest  output  1  burst request to instruction memory.
REQ-010 SHALL have port MemReadAddress  output  32  line-aligned burst base address.
REQ-011 SHALL have port MemDataIn  input  32  burst word from memory.
REQ-012 SHALL have port MemDataReady  input  1  one-cycle strobe per burst word, in ascending order from line base.

Function
REQ-013 Organisation SHALL be 2-way set-associative: word offset ReadAddress[2 +: log2(BLOCK_WORDS)], index next log2(NUM_SETS) bits, tag the remaining upper bits.
REQ-014 Each set SHALL hold one LRU bit, which points at the way not most recently hit or filled.
REQ-015 FSM states SHALL be IDLE, MEM_WAIT, REFILL; requests SHALL be sampled only in IDLE.
REQ-016 IDLE with ReadEnable=1 and a hit SHALL assert Ready with the hit word on the next edge (1-cycle latency), update LRU, and remain in IDLE.
REQ-017 IDLE with ReadEnable=1 and a miss SHALL latch the address, select the victim (an invalid way first, else the LRU way) and enter MEM_WAIT.
REQ-018 In MEM_WAIT, MemReadRequest SHALL be held at 1 with MemReadAddress = {tag,index,0} until the first MemDataReady; it SHALL then drop to 0 and the FSM SHALL enter REFILL, counting that word.
REQ-019 REFILL SHALL write each MemDataReady word into the victim line at the word counter position; after word BLOCK_WORDS-1 it SHALL set valid, write the tag, update LRU and return to IDLE.
REQ-020 Unless early restart is in effect, Ready and the requested word SHALL pulse on the edge at which the line completes.
REQ-021 MemDataReady in IDLE SHALL be ignored; ReadEnable and address changes during MEM_WAIT or REFILL SHALL be ignored.
REQ-022 Outside MEM_WAIT, MemReadRequest SHALL be 0; Ready SHALL never be high for two consecutive cycles.

Reset
REQ-023 While reset=0: all valid and LRU bits cleared, FSM IDLE, word counter 0, Ready=0, MemReadRequest=0, Instruction=0, MemReadAddress=0.
REQ-024 Reset mid-refill SHALL discard the partial line; residual memory strobes afterwards are ignored per REQ-021.

Configuration
REQ-025 Macro ICACHE_EARLY_RESTART_EN defined: Ready and Instruction SHALL pulse on the edge after the requested word's MemDataReady, while the refill continues; new requests SHALL still wait for IDLE.
REQ-026 Macro absent: Ready only per REQ-020; no forwarding path is generated.

Structure
REQ-027 A shared package/header SHALL hold the address-field width localparams, the FSM state encodings, and the default NUM_SETS/BLOCK_WORDS values.
REQ-028 One sub-module, ucsbece154_icache_way, SHALL hold the valid, tag and data arrays for one way, with a hit output; it is instantiated twice.

Verification (NUM_SETS=8, BLOCK_WORDS=4, text base 0x00010000)
REQ-029 Cold read 0x00010004 -> MemReadRequest with MemReadAddress 0x00010000, 4 strobes, Ready with word 1; then read 0x00010008 -> Ready 1 cycle later, no MemReadRequest.
REQ-030 Reads 0x00010000, 0x00010080, then a re-read of 0x00010080 -> two misses, then a hit; read 0x00010100 -> evicts the 0x00010000 line; 0x00010080 still hits; 0x00010000 misses.
REQ-031 Reset low after the 2nd MemDataReady -> all outputs 0; re-read of the same address misses and refetches the full line.
REQ-032 Read 0x00010000 -> with ICACHE_EARLY_RESTART_EN, Ready 1 cycle after the 1st strobe; without it, 1 cycle after the 4th strobe.
REQ-033 ReadAddress changed during REFILL, plus a stray MemDataReady in IDLE -> both ignored; the original request completes, no spurious Ready and no array write.

Source files
------------

// File: rtl/ucsbece154_icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154_icache_pkg
// Brief    : Shared defaults, address-field widths and FSM encodings.
// Revision : 1.0
// ============================================================================
package ucsbece154_icache_pkg;

    localparam int ADDR_W              = 32;
    localparam int DATA_W              = 32;
    localparam int BYTE_OFF_W          = 2;
    localparam int NUM_WAYS            = 2;
    localparam int DEFAULT_NUM_SETS    = 8;
    localparam int DEFAULT_BLOCK_WORDS = 4;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_REFILL   = 2'd2;

    function automatic int offset_width(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int index_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_width(input int num_sets, input int block_words);
        return ADDR_W - BYTE_OFF_W - $clog2(num_sets) - $clog2(block_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154_icache_if.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154_icache_if
// Brief    : CPU fetch port and instruction-memory burst port of the I-cache.
// Revision : 1.0
// ============================================================================
interface ucsbece154_icache_if;
    import ucsbece154_icache_pkg::*;

    logic              ReadEnable;
    logic [ADDR_W-1:0] ReadAddress;
    logic [DATA_W-1:0] Instruction;
    logic              Ready;
    logic              MemReadRequest;
    logic [ADDR_W-1:0] MemReadAddress;
    logic [DATA_W-1:0] MemDataIn;
    logic              MemDataReady;

    modport slave (
        input  ReadEnable, ReadAddress, MemDataIn, MemDataReady,
        output Instruction, Ready, MemReadRequest, MemReadAddress
    );

    modport master (
        output ReadEnable, ReadAddress, MemDataIn, MemDataReady,
        input  Instruction, Ready, MemReadRequest, MemReadAddress
    );
endinterface
`default_nettype wire

// File: rtl/ucsbece154_icache_way.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154_icache_way
// Brief    : One way of the I-cache: valid, tag and data arrays plus hit compare.
// Revision : 1.0
// ============================================================================
module ucsbece154_icache_way
    import ucsbece154_icache_pkg::*;
#(
    parameter int  NUM_SETS    = DEFAULT_NUM_SETS,
    parameter int  BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    localparam int OFF_W       = offset_width(BLOCK_WORDS),
    localparam int IDX_W       = index_width(NUM_SETS),
    localparam int TAG_W       = tag_width(NUM_SETS, BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_rd_index,
    input  logic [TAG_W-1:0]  i_rd_tag,
    input  logic [OFF_W-1:0]  i_rd_offset,
    output logic              o_valid,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_rd_word,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_index,
    input  logic [OFF_W-1:0]  i_wr_offset,
    input  logic [DATA_W-1:0] i_wr_word,
    input  logic              i_fill_done,
    input  logic [TAG_W-1:0]  i_fill_tag
);

    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [DATA_W-1:0]   r_data [NUM_SETS][BLOCK_WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_fill_done) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; a line is only visible once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_fill_done) begin
            r_tag[i_wr_index] <= i_fill_tag;
        end
        if (i_wr_en) begin
            r_data[i_wr_index][i_wr_offset] <= i_wr_word;
        end
    end

    assign o_valid   = r_valid[i_rd_index];
    assign o_hit     = o_valid && (r_tag[i_rd_index] == i_rd_tag);
    assign o_rd_word = r_data[i_rd_index][i_rd_offset];

endmodule
`default_nettype wire

// File: rtl/ucsbece154_icache.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154_icache
// Brief    : 2-way set-associative blocking I-cache with LRU and burst refill.
//            Define ICACHE_EARLY_RESTART_EN to return the word as soon as it arrives.
// Revision : 1.0
// ============================================================================
module ucsbece154_icache
    import ucsbece154_icache_pkg::*;
#(
    parameter int NUM_SETS    = DEFAULT_NUM_SETS,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    ucsbece154_icache_if.slave   bus
);

    localparam int OFF_W = offset_width(BLOCK_WORDS);
    localparam int IDX_W = index_width(NUM_SETS);
    localparam int TAG_W = tag_width(NUM_SETS, BLOCK_WORDS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [OFF_W-1:0]    r_count;
    logic [OFF_W-1:0]    r_off;
    logic [IDX_W-1:0]    r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic                r_victim;
    logic [NUM_SETS-1:0] r_lru;
    logic                r_ready;
    logic [DATA_W-1:0]   r_instr;
`ifndef ICACHE_EARLY_RESTART_EN
    logic [DATA_W-1:0]   r_capture;
`endif

    logic [OFF_W-1:0]    w_req_off;
    logic [IDX_W-1:0]    w_req_idx;
    logic [TAG_W-1:0]    w_req_tag;
    logic [NUM_WAYS-1:0] w_valid;
    logic [NUM_WAYS-1:0] w_hit;
    logic [DATA_W-1:0]   w_word [NUM_WAYS];
    logic                w_accept;
    logic                w_any_hit;
    logic [DATA_W-1:0]   w_hit_word;
    logic                w_victim;
    logic                w_strobe;
    logic                w_last;
    logic                w_mem_req;
    logic [ADDR_W-1:0]   w_mem_addr;

    assign w_req_off = bus.ReadAddress[BYTE_OFF_W +: OFF_W];
    assign w_req_idx = bus.ReadAddress[BYTE_OFF_W + OFF_W +: IDX_W];
    assign w_req_tag = bus.ReadAddress[ADDR_W-1 -: TAG_W];

    // A request is not re-sampled in the cycle its Ready is shown, so Ready never repeats.
    assign w_accept   = (r_state == S_IDLE) && bus.ReadEnable && !r_ready;
    assign w_any_hit  = |w_hit;
    assign w_hit_word = w_hit[1] ? w_word[1] : w_word[0];
    assign w_victim   = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_req_idx]);
    assign w_strobe   = bus.MemDataReady && ((r_state == S_MEM_WAIT) || (r_state == S_REFILL));
    assign w_last     = w_strobe && (r_count == LAST_WORD);

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        logic w_sel;
        assign w_sel = (g == 0) ? ~r_victim : r_victim;

        ucsbece154_icache_way #(
            .NUM_SETS    (NUM_SETS),
            .BLOCK_WORDS (BLOCK_WORDS)
        ) u_way (
            .clk         (clk),
            .reset       (reset),
            .i_rd_index  (w_req_idx),
            .i_rd_tag    (w_req_tag),
            .i_rd_offset (w_req_off),
            .o_valid     (w_valid[g]),
            .o_hit       (w_hit[g]),
            .o_rd_word   (w_word[g]),
            .i_wr_en     (w_strobe && w_sel),
            .i_wr_index  (r_idx),
            .i_wr_offset (r_count),
            .i_wr_word   (bus.MemDataIn),
            .i_fill_done (w_last && w_sel),
            .i_fill_tag  (r_tag)
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_accept && !w_any_hit) w_next_state = S_MEM_WAIT;
            S_MEM_WAIT: if (bus.MemDataReady)       w_next_state = S_REFILL;
            S_REFILL:   if (w_last)                 w_next_state = S_IDLE;
            default:                                w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_req  = 1'b0;
        w_mem_addr = '0;
        if (r_state == S_MEM_WAIT) begin
            w_mem_req  = 1'b1;
            w_mem_addr = {r_tag, r_idx, {(OFF_W + BYTE_OFF_W){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_off    <= '0;
            r_idx    <= '0;
            r_tag    <= '0;
            r_victim <= 1'b0;
            r_lru    <= '0;
            r_ready  <= 1'b0;
            r_instr  <= '0;
`ifndef ICACHE_EARLY_RESTART_EN
            r_capture <= '0;
`endif
        end else begin
            r_ready <= 1'b0;
            if (w_accept) begin
                if (w_any_hit) begin
                    r_ready            <= 1'b1;
                    r_instr            <= w_hit_word;
                    r_lru[w_req_idx]   <= ~w_hit[1];
                end else begin
                    r_off    <= w_req_off;
                    r_idx    <= w_req_idx;
                    r_tag    <= w_req_tag;
                    r_victim <= w_victim;
                end
            end
            if (w_strobe) begin
                r_count <= r_count + 1'b1;
`ifdef ICACHE_EARLY_RESTART_EN
                if (r_count == r_off) begin
                    r_ready <= 1'b1;
                    r_instr <= bus.MemDataIn;
                end
`else
                if (r_count == r_off) begin
                    r_capture <= bus.MemDataIn;
                end
                if (w_last) begin
                    r_ready <= 1'b1;
                    r_instr <= (r_count == r_off) ? bus.MemDataIn : r_capture;
                end
`endif
            end
            if (w_last) begin
                r_lru[r_idx] <= ~r_victim;
            end
        end
    end

    assign bus.Ready          = r_ready;
    assign bus.Instruction    = r_instr;
    assign bus.MemReadRequest = w_mem_req;
    assign bus.MemReadAddress = w_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucsbece154_icache
// Brief    : Scoreboard bench for the I-cache with a burst memory model.
// Revision : 1.0
// ============================================================================
module tb_ucsbece154_icache;

    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset;

    ucsbece154_icache_if bus();

    ucsbece154_icache #(
        .NUM_SETS    (8),
        .BLOCK_WORDS (BW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q [$];
    int          rd_idx = 0;

    int          burst_cnt     = 0;
    int          strobes_given = 0;
    int          mem_limit     = BW;
    int          stray_req     = 0;
    int          stray_ack     = 0;
    bit          mem_busy      = 1'b0;
    logic [31:0] burst_addr    = '0;
    int          strobe_cyc [BW];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Memory: one idle cycle between strobes; stops after mem_limit words.
    initial begin : mem_model
        logic [31:0] base;
        bus.MemDataReady = 1'b0;
        bus.MemDataIn    = '0;
        forever begin
            @(negedge clk);
            bus.MemDataReady = 1'b0;
            if (stray_req != stray_ack) begin
                stray_ack        = stray_req;
                bus.MemDataReady = 1'b1;
                bus.MemDataIn    = 32'hDEAD_BEEF;
            end else if (reset && bus.MemReadRequest) begin
                base          = bus.MemReadAddress;
                burst_addr    = base;
                burst_cnt++;
                strobes_given = 0;
                mem_busy      = 1'b1;
                for (int i = 0; i < BW && i < mem_limit; i++) begin
                    @(negedge clk);
                    bus.MemDataReady = 1'b0;
                    @(negedge clk);
                    bus.MemDataReady = 1'b1;
                    bus.MemDataIn    = memword(base + 32'(4 * i));
                    strobe_cyc[i]    = cyc;
                    strobes_given    = i + 1;
                end
                @(negedge clk);
                bus.MemDataReady = 1'b0;
                mem_busy         = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit prev_ready;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.Ready === 1'b1) begin
                check("ready_single_cycle", 32'(prev_ready), 32'd0);
                if (rd_idx < sb_q.size()) begin
                    check("instruction", bus.Instruction, sb_q[rd_idx]);
                    rd_idx++;
                end else begin
                    check("spurious_ready", 32'(bus.Ready), 32'd0);
                end
            end
            prev_ready = (bus.Ready === 1'b1);
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_word,
                         input bit exp_miss, input bit disturb, input string nm);
        int b0, t0, tr, k;
        bit got;
        b0  = burst_cnt;
        got = 1'b0;
        tr  = 0;
        @(negedge clk);
        bus.ReadEnable  = 1'b1;
        bus.ReadAddress = a;
        sb_q.push_back(exp_word);
        t0 = cyc;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (bus.Ready === 1'b1) begin
                got = 1'b1;
                tr  = cyc;
            end else if (disturb && burst_cnt != b0 && strobes_given >= 2) begin
                bus.ReadAddress = 32'h0001_0200;
            end
        end
        bus.ReadEnable = 1'b0;
        check({nm, "_ready"}, 32'(got), 32'd1);
        for (int i = 0; i < 40 && mem_busy; i++) @(negedge clk);
        check({nm, "_bursts"}, 32'(burst_cnt - b0), exp_miss ? 32'd1 : 32'd0);
        if (got && exp_miss) begin
            check({nm, "_burst_addr"}, burst_addr, {a[31:4], 4'h0});
            check({nm, "_strobes"}, 32'(strobes_given), 32'(BW));
`ifdef ICACHE_EARLY_RESTART_EN
            k = int'(a[3:2]);
`else
            k = BW - 1;
`endif
            check({nm, "_latency"}, 32'(tr), 32'(strobe_cyc[k] + 1));
        end else if (got) begin
            check({nm, "_latency"}, 32'(tr - t0), 32'd1);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_ready"},     32'(bus.Ready),          32'd0);
        check({nm, "_memreq"},    32'(bus.MemReadRequest), 32'd0);
        check({nm, "_instr"},     bus.Instruction,         32'd0);
        check({nm, "_memaddr"},   bus.MemReadAddress,      32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin : main
        int b0;
        reset           = 1'b0;
        bus.ReadEnable  = 1'b0;
        bus.ReadAddress = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;

        // Cold miss then hit in the same line
        fetch(32'h0001_0004, 32'hC0DF_0004, 1'b1, 1'b0, "cold_miss");
        fetch(32'h0001_0008, 32'hC0DF_0008, 1'b0, 1'b0, "same_line_hit");

        // LRU replacement in set 0
        pulse_reset();
        fetch(32'h0001_0000, 32'hC0DF_0000, 1'b1, 1'b0, "lru_a_miss");
        fetch(32'h0001_0080, 32'hC0DF_0080, 1'b1, 1'b0, "lru_b_miss");
        fetch(32'h0001_0080, 32'hC0DF_0080, 1'b0, 1'b0, "lru_b_hit");
        fetch(32'h0001_0100, 32'hC0DF_0100, 1'b1, 1'b0, "lru_c_evicts_a");
        fetch(32'h0001_0104, 32'hC0DF_0104, 1'b0, 1'b0, "lru_c_hit");
        fetch(32'h0001_0080, 32'hC0DF_0080, 1'b0, 1'b0, "lru_b_still_hit");
        fetch(32'h0001_0000, 32'hC0DF_0000, 1'b1, 1'b0, "lru_a_refetch");

        // Address change during refill, then a stray strobe while idle
        fetch(32'h0001_0040, 32'hC0DF_0040, 1'b1, 1'b1, "disturbed_refill");
        stray_req++;
        repeat (4) @(negedge clk);
        fetch(32'h0001_004C, 32'hC0DF_004C, 1'b0, 1'b0, "after_stray_hit3");
        fetch(32'h0001_0040, 32'hC0DF_0040, 1'b0, 1'b0, "after_stray_hit0");
        fetch(32'h0001_0200, 32'hC0DF_0200, 1'b1, 1'b0, "changed_addr_miss");

        // Reset in the middle of a refill discards the partial line
        b0        = burst_cnt;
        mem_limit = 2;
        @(negedge clk);
        bus.ReadEnable  = 1'b1;
        bus.ReadAddress = 32'h0001_001C;
        for (int i = 0; i < 60 && !(burst_cnt != b0 && strobes_given == 2); i++) @(negedge clk);
        check("midrefill_strobes", 32'(strobes_given), 32'd2);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_outputs_zero("midrefill_reset");
        bus.ReadEnable = 1'b0;
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        mem_limit = BW;
        stray_req++;
        repeat (4) @(negedge clk);
        fetch(32'h0001_001C, 32'hC0DF_001C, 1'b1, 1'b0, "refetch_after_reset");

        repeat (4) @(negedge clk);
        check("responses_seen", 32'(rd_idx), 32'(sb_q.size()));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
